// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// default oversampling ratio used by the UART blocks.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uartRxState_e;

endpackage : uart_pkg

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the UART receiver: a 2-flop synchronizer on the
// asynchronous rx pin plus the bit-decision value used at sample points.
// Define UART_RX_MAJORITY_EN to make each decision a 2-of-3 vote over the
// synchronized line at the decision edge and the two edges before it;
// otherwise the decision is the synchronized line itself.
module uart_rx_sampler (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rxSync,
  output logic rxVote
);

  logic [1:0] syncFf;

  // Two-stage synchronizer; both stages idle high so reset never looks like a start bit.
  // NOTE: flops are written with non-blocking (<=) so every register samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncFf <= 2'b11;
    end else begin
      syncFf <= {syncFf[0], rx};
    end
  end

  assign rxSync = syncFf[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // History of the synchronized line for the previous two edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rxSync};
    end
  end

  assign rxVote = (rxSync & hist[0]) | (rxSync & hist[1]) | (hist[0] & hist[1]);
`else
  assign rxVote = rxSync;
`endif

endmodule : uart_rx_sampler

// File: rtl/uart_rx.sv
// UART 8N1 receiver. Oversamples the serial line CLKS_PER_BIT times per bit,
// checks the start bit at mid-bit, then samples data and stop bits one bit
// period apart. Good frames update rxData with a dataValid pulse; a low stop
// bit gives a frameError pulse and the receiver waits for the line to return
// high. Optional UART_RX_MAJORITY_EN enables 2-of-3 voting in the sampler.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rxData,
  output logic                      dataValid,
  output logic                      frameError,
  output logic                      busy
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic rxSync;
  logic rxVote;

  uartRxState_e              state, stateNext;
  logic [CNT_W-1:0]          clkCnt, clkCntNext;
  logic [2:0]                bitIdx, bitIdxNext;
  logic [UART_DATA_BITS-1:0] shift, shiftNext;
  logic [UART_DATA_BITS-1:0] rxDataNext;
  logic                      dataValidNext;
  logic                      frameErrorNext;

  uart_rx_sampler uSampler (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .rxSync (rxSync),
    .rxVote (rxVote)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clkCnt     <= '0;
      bitIdx     <= '0;
      shift      <= '0;
      rxData     <= '0;
      dataValid  <= 1'b0;
      frameError <= 1'b0;
    end else begin
      state      <= stateNext;
      clkCnt     <= clkCntNext;
      bitIdx     <= bitIdxNext;
      shift      <= shiftNext;
      rxData     <= rxDataNext;
      dataValid  <= dataValidNext;
      frameError <= frameErrorNext;
    end
  end

  // Next-state and output decode for the frame FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    stateNext      = state;
    clkCntNext     = clkCnt;
    bitIdxNext     = bitIdx;
    shiftNext      = shift;
    rxDataNext     = rxData;
    dataValidNext  = 1'b0;
    frameErrorNext = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rxSync) begin
          stateNext  = START;
          clkCntNext = '0;
        end
      end

      START: begin
        if (clkCnt == HALF_LAST) begin
          clkCntNext = '0;
          if (!rxVote) begin
            stateNext  = DATA;
            bitIdxNext = '0;
          end else begin
            stateNext = IDLE;  // glitch: line back high at mid start bit
          end
        end else begin
          clkCntNext = clkCnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (clkCnt == BIT_LAST) begin
          clkCntNext        = '0;
          shiftNext[bitIdx] = rxVote;
          if (bitIdx == IDX_LAST) begin
            stateNext = STOP;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
          end
        end else begin
          clkCntNext = clkCnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (clkCnt == BIT_LAST) begin
          clkCntNext = '0;
          if (rxVote) begin
            rxDataNext    = shift;
            dataValidNext = 1'b1;
            stateNext     = IDLE;
          end else begin
            frameErrorNext = 1'b1;
            stateNext      = BREAK;
          end
        end else begin
          clkCntNext = clkCnt + CNT_W'(1);
        end
      end

      BREAK: begin
        if (rxSync) begin
          stateNext = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit. Directed cases cover
// latency, back-to-back frames, glitch rejection, framing error with a held
// break, reset mid-frame and sample-point spikes; a randomized section is
// checked against a frame-level model built from the latency rule.
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;
  localparam int LAT = 2 + H + 9 * C;  // 154 for 16 clocks per bit

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rxData;
  logic       dataValid;
  logic       frameError;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int overlap = 0;

  // Monitor results
  int         dvCyc[$];
  logic [7:0] dvDat[$];
  int         feCyc[$];

  logic [7:0] lastGood;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rxData     (rxData),
    .dataValid  (dataValid),
    .frameError (frameError),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record output pulses half a cycle after the edge that produced them.
  always @(negedge clk) begin
    if (dataValid) begin
      dvCyc.push_back(cyc);
      dvDat.push_back(rxData);
    end
    if (frameError) feCyc.push_back(cyc);
    if (dataValid && frameError) overlap++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearMon();
    dvCyc.delete();
    dvDat.delete();
    feCyc.delete();
  endtask

  task automatic driveLevel(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      rx = v;
      @(posedge clk);
      #1;
    end
  endtask

  // One full frame; spikeMask inverts the line for the single cycle that the
  // receiver samples at the middle of each selected data bit.
  task automatic sendFrame(input logic [7:0] b, input logic stopBit,
                           input logic [7:0] spikeMask, output int eStart);
    eStart = cyc + 1;
    driveLevel(1'b0, C);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < C; i++) begin
        rx = (spikeMask[k] && i == H) ? ~b[k] : b[k];
        @(posedge clk);
        #1;
      end
    end
    driveLevel(stopBit, C);
  endtask

  initial begin
    int e, e0, e1, e2, n;
    logic [7:0] spikeExp;
    logic [7:0] bytes3[3];
    int         expDvCyc[$];
    logic [7:0] expDvDat[$];
    int         expFeCyc[$];

    // Reset
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_rxData", rxData, 8'h00);
    check("reset_dataValid", dataValid, 1'b0);
    check("reset_frameError", frameError, 1'b0);
    check("reset_busy", busy, 1'b0);
    driveLevel(1'b1, 4);

    // Clean 0xA5
    clearMon();
    sendFrame(8'hA5, 1'b1, 8'h00, e);
    driveLevel(1'b1, 2 * C);
    check("a5_dv_count", dvCyc.size(), 1);
    if (dvCyc.size() > 0) begin
      check("a5_dv_cycle", dvCyc[0], e + 154);
      check("a5_dv_data", dvDat[0], 8'hA5);
    end
    check("a5_rxData_held", rxData, 8'hA5);
    check("a5_fe_count", feCyc.size(), 0);
    lastGood = 8'hA5;

    // Back-to-back 0x00, 0xFF, 0x3C
    clearMon();
    bytes3[0] = 8'h00; bytes3[1] = 8'hFF; bytes3[2] = 8'h3C;
    sendFrame(bytes3[0], 1'b1, 8'h00, e0);
    sendFrame(bytes3[1], 1'b1, 8'h00, e1);
    sendFrame(bytes3[2], 1'b1, 8'h00, e2);
    driveLevel(1'b1, 2 * C);
    check("b2b_dv_count", dvCyc.size(), 3);
    for (int i = 0; i < 3 && i < dvCyc.size(); i++) begin
      check($sformatf("b2b_data%0d", i), dvDat[i], bytes3[i]);
      check($sformatf("b2b_cycle%0d", i), dvCyc[i], ((i == 0) ? e0 : (i == 1) ? e1 : e2) + LAT);
    end
    check("b2b_fe_count", feCyc.size(), 0);
    lastGood = 8'h3C;

    // 3-cycle glitch
    clearMon();
    driveLevel(1'b0, 3);
    rx = 1'b1;
    check("glitch_busy_set", busy, 1'b1);
    n = 0;
    while (busy && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("glitch_busy_clear", busy, 1'b0);
    driveLevel(1'b1, 2 * C);
    check("glitch_dv_count", dvCyc.size(), 0);
    check("glitch_fe_count", feCyc.size(), 0);

    // 0x55 with low stop bit, line held low 40 bit-times
    clearMon();
    sendFrame(8'h55, 1'b0, 8'h00, e);
    driveLevel(1'b0, 40 * C);
    check("brk_fe_count", feCyc.size(), 1);
    if (feCyc.size() > 0) check("brk_fe_cycle", feCyc[0], e + LAT);
    check("brk_dv_count", dvCyc.size(), 0);
    check("brk_rxData_kept", rxData, lastGood);
    check("brk_busy_held", busy, 1'b1);
    driveLevel(1'b1, 3 * C);
    check("brk_fe_after_release", feCyc.size(), 1);
    check("brk_dv_after_release", dvCyc.size(), 0);
    check("brk_busy_released", busy, 1'b0);

    // Reset mid-DATA on 0x81, then clean 0x42
    clearMon();
    driveLevel(1'b0, C);
    driveLevel(1'b1, C);   // bit0 of 0x81
    driveLevel(1'b0, 2 * C);  // bits 1..2
    check("rstmid_busy_before", busy, 1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_rxData", rxData, 8'h00);
    driveLevel(1'b1, C);
    check("rstmid_no_pulse", dvCyc.size() + feCyc.size(), 0);
    sendFrame(8'h42, 1'b1, 8'h00, e);
    driveLevel(1'b1, 2 * C);
    check("rstmid_dv_count", dvCyc.size(), 1);
    if (dvCyc.size() > 0) check("rstmid_dv_data", dvDat[0], 8'h42);
    check("rstmid_fe_count", feCyc.size(), 0);
    lastGood = 8'h42;

    // Spikes at each data sample point of 0x96
`ifdef UART_RX_MAJORITY_EN
    spikeExp = 8'h96;
`else
    spikeExp = 8'h69;
`endif
    clearMon();
    sendFrame(8'h96, 1'b1, 8'hFF, e);
    driveLevel(1'b1, 2 * C);
    check("spike_dv_count", dvCyc.size(), 1);
    if (dvCyc.size() > 0) check("spike_dv_data", dvDat[0], spikeExp);
    lastGood = spikeExp;

    // Randomized frames against a frame-level model
    clearMon();
    for (int f = 0; f < 24; f++) begin
      logic [7:0] b;
      logic       bad;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      sendFrame(b, ~bad, 8'h00, e);
      if (bad) begin
        expFeCyc.push_back(e + LAT);
        driveLevel(1'b0, $urandom_range(0, 3) * C);
        driveLevel(1'b1, C + $urandom_range(0, C));
      end else begin
        expDvCyc.push_back(e + LAT);
        expDvDat.push_back(b);
        lastGood = b;
        driveLevel(1'b1, $urandom_range(0, 2 * C));
      end
    end
    driveLevel(1'b1, 2 * C);
    check("rand_dv_count", dvCyc.size(), expDvCyc.size());
    check("rand_fe_count", feCyc.size(), expFeCyc.size());
    for (int i = 0; i < expDvCyc.size() && i < dvCyc.size(); i++) begin
      check($sformatf("rand_dv_cycle%0d", i), dvCyc[i], expDvCyc[i]);
      check($sformatf("rand_dv_data%0d", i), dvDat[i], expDvDat[i]);
    end
    for (int i = 0; i < expFeCyc.size() && i < feCyc.size(); i++) begin
      check($sformatf("rand_fe_cycle%0d", i), feCyc[i], expFeCyc[i]);
    end
    check("rand_rxData_final", rxData, lastGood);
    check("rand_busy_idle", busy, 1'b0);

    check("no_dv_fe_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_rx
